uart_tx_buffered: RTL

//   Next-generation UART transmitter: FIFO-buffered, with runtime-selectable 5..DATA_WIDTH data bits,

---
 rtl/uart_tx_buffered_if.sv | 13 +
 rtl/uart_tx_buffered.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered_if.sv
// Write-side handshake bundle for uart_tx_buffered.
// A word moves from master to slave on a clock edge where write && ready are both high;
// data must be stable while write is high, and ready never depends on write in the same cycle.
interface uart_tx_buffered_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  write;
    logic                  ready;

    modport master (output data, output write, input ready);
    modport slave  (input data, input write, output ready);
endinterface

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered UART transmitter with runtime frame format (5..DATA_WIDTH data bits,
// optional parity, 1 or 2 stop bits) and a 12-bit-time idle guard after reset.
// Optional build macro UART_TX_CTS_EN adds an active-low clear-to-send input that gates
// the start of each new frame (never aborts a frame already on the line).
// The line output is registered, so it trails the FSM state by exactly one clock.
module uart_tx_buffered #(
    parameter int CLOCK_DIVIDER_WIDTH = 16,
    parameter int DATA_WIDTH          = 8,
    parameter int FIFO_DEPTH          = 16
) (
    input  logic                           clock_i,
    input  logic                           reset_i,
    input  logic [CLOCK_DIVIDER_WIDTH-1:0] clock_divider_i,
    input  logic [3:0]                     data_bits_i,
    input  logic                           two_stop_bits_i,
    input  logic                           parity_bit_i,
    input  logic                           parity_even_i,
    uart_tx_buffered_if.slave              wr,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count_o,
    output logic                           busy_o,
    output logic                           serial_o,
`ifdef UART_TX_CTS_EN
    input  logic                           cts_n_i,
`endif
    output logic [2:0]                     state_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = CLOCK_DIVIDER_WIDTH;
    localparam logic [3:0] MAX_BITS = 4'(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_GUARD  = 3'd0,
        S_IDLE   = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [DW-1:0]         baud_q, baud_d;
    logic [3:0]            bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [3:0]            nbits_q, nbits_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  two_stop_q, two_stop_d;
    logic                  serial_q, serial_d;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic                  full, push, pop, cts_ok, tick;
    logic [DW-1:0]         div_m1;
    logic [3:0]            nb_c;
    logic [DATA_WIDTH-1:0] mask, head;

`ifdef UART_TX_CTS_EN
    logic [1:0] cts_sync_q;

    // Two-flop synchroniser; resets to "not clear" so nothing starts before CTS is seen.
    always_ff @(posedge clock_i) begin
        if (reset_i) cts_sync_q <= 2'b11;
        else         cts_sync_q <= {cts_sync_q[0], cts_n_i};
    end
    assign cts_ok = ~cts_sync_q[1];
`else
    assign cts_ok = 1'b1;
`endif

    assign full         = (count_q == CW'(FIFO_DEPTH));
    assign wr.ready     = !full && (state_q != S_GUARD);
    assign push         = wr.write && wr.ready;
    assign head         = mem[rd_ptr_q];
    assign fifo_count_o = count_q;
    assign busy_o       = reset_i || (state_q != S_IDLE) || (count_q != '0);
    assign serial_o     = serial_q;
    assign state_o      = state_q;
    assign div_m1       = (clock_divider_i == '0) ? '0 : clock_divider_i - DW'(1);
    assign tick         = (baud_q == '0);

    // Clamp the requested data-bit count and build the mask of active data bits.
    always_comb begin
        nb_c = data_bits_i;
        if (data_bits_i < 4'd5)          nb_c = 4'd5;
        else if (data_bits_i > MAX_BITS) nb_c = MAX_BITS;
        mask = '0;
        for (int i = 0; i < DATA_WIDTH; i++) mask[i] = (i < int'(nb_c));
    end

    // FIFO storage; written on every accepted push.
    always_ff @(posedge clock_i) begin
        if (push) mem[wr_ptr_q] <= wr.data;
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FSM and datapath registers; reset drops into the guard interval with the line high.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= S_GUARD;
            baud_q     <= div_m1;
            bit_q      <= '0;
            shift_q    <= '0;
            nbits_q    <= 4'd5;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            serial_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            nbits_q    <= nbits_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            two_stop_q <= two_stop_d;
            serial_q   <= serial_d;
        end
    end

    // Next-state logic: each bit lasts until the baud counter reaches zero, then the
    // divider is re-sampled for the following bit.
    always_comb begin
        state_d    = state_q;
        baud_d     = tick ? div_m1 : baud_q - DW'(1);
        bit_d      = bit_q;
        shift_d    = shift_q;
        nbits_d    = nbits_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        two_stop_d = two_stop_q;
        pop        = 1'b0;
        case (state_q)
            S_GUARD: begin
                if (tick) begin
                    if (bit_q == 4'd11) begin
                        state_d = S_IDLE;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            S_IDLE: begin
                if ((count_q != '0) && cts_ok) begin
                    pop        = 1'b1;
                    shift_d    = head & mask;
                    nbits_d    = nb_c;
                    par_en_d   = parity_bit_i;
                    par_bit_d  = parity_even_i ? ^(head & mask) : ~^(head & mask);
                    two_stop_d = two_stop_bits_i;
                    bit_d      = '0;
                    baud_d     = div_m1;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (tick) state_d = S_DATA;
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == nbits_q - 4'd1) begin
                        bit_d   = '0;
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) state_d = S_STOP;
            end
            S_STOP: begin
                if (tick) begin
                    if (two_stop_q && (bit_q == '0)) begin
                        bit_d = 4'd1;
                    end else begin
                        bit_d   = '0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_GUARD;
        endcase
    end

    // Line level for the current state, registered on the next edge.
    always_comb begin
        serial_d = 1'b1;
        case (state_q)
            S_START:  serial_d = 1'b0;
            S_DATA:   serial_d = shift_q[0];
            S_PARITY: serial_d = par_bit_q;
            default:  serial_d = 1'b1;
        endcase
    end
endmodule
